// File: rtl/reg_f_wb_sched_if.sv
// Bundle of issue, writeback, read-address and register-file write signals around the scheduler.
// Latency: none, wires only.
// Backpressure: the scheduler answers issue with issue_ready and each writeback source with its own ready.
interface reg_f_wb_sched_if #(
    parameter int DataSize = 32,
    parameter int AddrSize = 5
);
    logic                issue_valid;
    logic [AddrSize-1:0] issue_address;
    logic                issue_ready;
    logic                alu_valid;
    logic [AddrSize-1:0] alu_address;
    logic [DataSize-1:0] alu_data;
    logic                alu_ready;
    logic                mem_valid;
    logic [AddrSize-1:0] mem_address;
    logic [DataSize-1:0] mem_data;
    logic                mem_ready;
    logic [AddrSize-1:0] read_address0;
    logic [AddrSize-1:0] read_address1;
    logic [AddrSize-1:0] read_address2;
    logic                stall;
    logic                rf_write;
    logic [AddrSize-1:0] rf_write_address;
    logic [DataSize-1:0] rf_write_data;
    logic                sb_error;

    // Pipeline side: drives requests, sees handshakes and stall.
    modport master (
        output issue_valid, issue_address,
        output alu_valid, alu_address, alu_data,
        output mem_valid, mem_address, mem_data,
        output read_address0, read_address1, read_address2,
        input  issue_ready, alu_ready, mem_ready, stall,
        input  rf_write, rf_write_address, rf_write_data, sb_error
    );

    // Scheduler side.
    modport slave (
        input  issue_valid, issue_address,
        input  alu_valid, alu_address, alu_data,
        input  mem_valid, mem_address, mem_data,
        input  read_address0, read_address1, read_address2,
        output issue_ready, alu_ready, mem_ready, stall,
        output rf_write, rf_write_address, rf_write_data, sb_error
    );
endinterface

// File: rtl/reg_f_wb_sched.sv
// Writeback scheduler for the register file write port (ALU/MEM arbitration) plus a per-register pending-write scoreboard.
// Latency: a grant in cycle N drives rf_write in N+1; stall/issue_ready/ready signals are combinational from state.
// Backpressure: issue is refused while the destination counter is saturated; the losing writeback source holds its request.
module reg_f_wb_sched #(
    parameter int DataSize    = 32,
    parameter int AddrSize    = 5,
    parameter int StarveLimit = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    reg_f_wb_sched_if.slave    bus
);
    localparam int NumRegs = 1 << AddrSize;

    logic [1:0]          r_cnt [NumRegs];
    logic [1:0]          w_cnt_nxt [NumRegs];
    logic [2:0]          r_starve;
    logic                r_rf_write;
    logic [AddrSize-1:0] r_rf_write_address;
    logic [DataSize-1:0] r_rf_write_data;
    logic                r_sb_error;

    logic                w_alu_pri;
    logic                w_alu_gnt;
    logic                w_mem_gnt;
    logic                w_gnt;
    logic [AddrSize-1:0] w_gnt_addr;
    logic [DataSize-1:0] w_gnt_data;
    logic                w_issue_fire;

    // ALU jumps ahead of MEM only once it has been starved long enough.
    assign w_alu_pri    = (32'(r_starve) >= StarveLimit);
    assign w_issue_fire = bus.issue_valid && bus.issue_ready;

    // Single-winner arbitration; the losing source stays pending.
    always_comb begin
        w_alu_gnt  = 1'b0;
        w_mem_gnt  = 1'b0;
        if (w_alu_pri) begin
            w_alu_gnt = bus.alu_valid;
            w_mem_gnt = bus.mem_valid && !bus.alu_valid;
        end else begin
            w_mem_gnt = bus.mem_valid;
            w_alu_gnt = bus.alu_valid && !bus.mem_valid;
        end
        w_gnt      = w_alu_gnt || w_mem_gnt;
        w_gnt_addr = w_alu_gnt ? bus.alu_address : bus.mem_address;
        w_gnt_data = w_alu_gnt ? bus.alu_data    : bus.mem_data;
    end

    // Next pending count per register: issue adds, commit removes, both together cancel; never wraps below zero.
    always_comb begin
        for (int i = 0; i < NumRegs; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (w_issue_fire && (bus.issue_address == AddrSize'(i))) begin
                if (!(w_gnt && (w_gnt_addr == AddrSize'(i)))) begin
                    w_cnt_nxt[i] = r_cnt[i] + 2'd1;
                end
            end else if (w_gnt && (w_gnt_addr == AddrSize'(i)) && (r_cnt[i] != 2'd0)) begin
                w_cnt_nxt[i] = r_cnt[i] - 2'd1;
            end
        end
    end

    // Scoreboard counters.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < NumRegs; i++) begin
            if (i_reset) begin
                r_cnt[i] <= 2'd0;
            end else begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    // Starvation counter: grows while ALU waits, clears on ALU grant or when ALU is idle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_starve <= 3'd0;
        end else if (!bus.alu_valid || w_alu_gnt) begin
            r_starve <= 3'd0;
        end else if (r_starve != 3'd7) begin
            r_starve <= r_starve + 3'd1;
        end
    end

    // Registered write port; address/data hold when idle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rf_write         <= 1'b0;
            r_rf_write_address <= '0;
            r_rf_write_data    <= '0;
        end else begin
            r_rf_write <= w_gnt;
            if (w_gnt) begin
                r_rf_write_address <= w_gnt_addr;
                r_rf_write_data    <= w_gnt_data;
            end
        end
    end

    // Sticky flag for a commit that had no outstanding issue behind it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sb_error <= 1'b0;
        end else if (w_gnt && (r_cnt[w_gnt_addr] == 2'd0)) begin
            r_sb_error <= 1'b1;
        end
    end

    assign bus.issue_ready      = (r_cnt[bus.issue_address] != 2'd3);
    assign bus.alu_ready        = w_alu_gnt;
    assign bus.mem_ready        = w_mem_gnt;
    assign bus.stall            = (r_cnt[bus.read_address0] != 2'd0) |
                                  (r_cnt[bus.read_address1] != 2'd0) |
                                  (r_cnt[bus.read_address2] != 2'd0);
    assign bus.rf_write         = r_rf_write;
    assign bus.rf_write_address = r_rf_write_address;
    assign bus.rf_write_data    = r_rf_write_data;
    assign bus.sb_error         = r_sb_error;
endmodule

// File: tb/tb_reg_f_wb_sched.sv
// Directed bench for the writeback scheduler with a small register file model on the write port.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled before the next edge.
// Backpressure: bench requesters simply hold valid and observe the ready/grant lines.
module tb_reg_f_wb_sched;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    reg_f_wb_sched_if #(.DataSize(32), .AddrSize(5)) bus();

    reg_f_wb_sched #(.DataSize(32), .AddrSize(5), .StarveLimit(4)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    // Register file model: write performed at the edge following rf_write.
    logic [31:0] rf_mem [32];
    always @(posedge clk) begin
        if (bus.rf_write) rf_mem[bus.rf_write_address] <= bus.rf_write_data;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.issue_valid   = 1'b0;
        bus.issue_address = '0;
        bus.alu_valid     = 1'b0;
        bus.alu_address   = '0;
        bus.alu_data      = '0;
        bus.mem_valid     = 1'b0;
        bus.mem_address   = '0;
        bus.mem_data      = '0;
        bus.read_address0 = '0;
        bus.read_address1 = '0;
        bus.read_address2 = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.issue_valid = 1'b1; bus.issue_address = 5'd4;
        bus.alu_valid = 1'b1; bus.alu_address = 5'd4; bus.alu_data = 32'h1111_1111;
        bus.mem_valid = 1'b1; bus.mem_address = 5'd6; bus.mem_data = 32'h2222_2222;
        bus.read_address0 = 5'd4; bus.read_address1 = 5'd6; bus.read_address2 = 5'd0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.issue_valid = 1'b0; bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
        #1;
        tests++; if (bus.rf_write !== 1'b0) begin fails++; $display("FAIL reset_rf_write got %b want 0", bus.rf_write); end
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", bus.stall); end
        tests++; if (bus.sb_error !== 1'b0) begin fails++; $display("FAIL reset_sb_error got %b want 0", bus.sb_error); end
        tests++; if (bus.issue_ready !== 1'b1) begin fails++; $display("FAIL reset_issue_ready got %b want 1", bus.issue_ready); end
        tests++; if (bus.rf_write_address !== 5'd0 || bus.rf_write_data !== 32'd0) begin
            fails++; $display("FAIL reset_wr_bus got %0d/%h want 0/0", bus.rf_write_address, bus.rf_write_data); end
    endtask

    task automatic test_hazard();
        do_reset();
        bus.issue_valid = 1'b1; bus.issue_address = 5'd5;
        #1;
        tests++; if (bus.issue_ready !== 1'b1) begin fails++; $display("FAIL hz_issue_ready got %b want 1", bus.issue_ready); end
        step();
        bus.issue_valid = 1'b0;
        bus.read_address0 = 5'd5;
        #1;
        tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL hz_stall_set got %b want 1", bus.stall); end
        bus.alu_valid = 1'b1; bus.alu_address = 5'd5; bus.alu_data = 32'hDEAD_BEEF;
        #1;
        tests++; if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b0) begin
            fails++; $display("FAIL hz_grant got alu=%b mem=%b want 1/0", bus.alu_ready, bus.mem_ready); end
        step();
        bus.alu_valid = 1'b0;
        #1;
        tests++; if (bus.rf_write !== 1'b1 || bus.rf_write_address !== 5'd5 || bus.rf_write_data !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL hz_write got %b/%0d/%h want 1/5/deadbeef", bus.rf_write, bus.rf_write_address, bus.rf_write_data); end
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL hz_stall_release got %b want 0", bus.stall); end
        step();
        tests++; if (rf_mem[5] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL hz_rf_read got %h want deadbeef", rf_mem[5]); end
        tests++; if (bus.rf_write !== 1'b0 || bus.sb_error !== 1'b0) begin
            fails++; $display("FAIL hz_idle got wr=%b err=%b want 0/0", bus.rf_write, bus.sb_error); end
    endtask

    task automatic test_saturation();
        do_reset();
        bus.read_address0 = 5'd7;
        bus.issue_address = 5'd7;
        for (int k = 0; k < 3; k++) begin
            bus.issue_valid = 1'b1;
            #1;
            tests++; if (bus.issue_ready !== 1'b1) begin fails++; $display("FAIL sat_issue%0d got %b want 1", k, bus.issue_ready); end
            step();
        end
        // Counter at 3: issue refused, commit offered in the same cycle.
        bus.alu_valid = 1'b1; bus.alu_address = 5'd7; bus.alu_data = 32'h7777_0001;
        #1;
        tests++; if (bus.issue_ready !== 1'b0) begin fails++; $display("FAIL sat_full got %b want 0", bus.issue_ready); end
        step();
        bus.issue_valid = 1'b0;
        bus.alu_data = 32'h7777_0002;
        #1;
        tests++; if (bus.alu_ready !== 1'b1) begin fails++; $display("FAIL sat_commit_gnt got %b want 1", bus.alu_ready); end
        step();
        bus.alu_valid = 1'b0;
        #1;
        tests++; if (bus.issue_ready !== 1'b1) begin fails++; $display("FAIL sat_unfull got %b want 1", bus.issue_ready); end
        tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL sat_still_pending got %b want 1", bus.stall); end
        tests++; if (bus.sb_error !== 1'b0) begin fails++; $display("FAIL sat_no_err got %b want 0", bus.sb_error); end
    endtask

    task automatic test_issue_commit_same();
        do_reset();
        bus.read_address1 = 5'd4;
        bus.issue_valid = 1'b1; bus.issue_address = 5'd4;
        step();
        // Issue and commit r4 together: count stays at 1.
        bus.mem_valid = 1'b1; bus.mem_address = 5'd4; bus.mem_data = 32'h0000_0044;
        step();
        bus.issue_valid = 1'b0;
        #1;
        tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL same_net_zero stall got %b want 1", bus.stall); end
        step();
        bus.mem_valid = 1'b0;
        #1;
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL same_drained stall got %b want 0", bus.stall); end
        tests++; if (bus.sb_error !== 1'b0) begin fails++; $display("FAIL same_no_err got %b want 0", bus.sb_error); end
    endtask

    task automatic test_priority();
        logic [4:0] prev_addr;
        logic       exp_alu;
        do_reset();
        prev_addr = 5'd0;
        bus.alu_valid = 1'b1; bus.alu_address = 5'd9;  bus.alu_data = 32'hA1A1_A1A1;
        bus.mem_valid = 1'b1; bus.mem_address = 5'd10; bus.mem_data = 32'hB2B2_B2B2;
        for (int k = 0; k < 10; k++) begin
            #1;
            exp_alu = ((k % 5) == 4);
            tests++; if (bus.alu_ready !== exp_alu || bus.mem_ready !== !exp_alu) begin
                fails++; $display("FAIL prio_cycle%0d got alu=%b mem=%b want alu=%b", k, bus.alu_ready, bus.mem_ready, exp_alu); end
            if (k > 0) begin
                tests++; if (bus.rf_write !== 1'b1 || bus.rf_write_address !== prev_addr) begin
                    fails++; $display("FAIL prio_wr%0d got %b/%0d want 1/%0d", k, bus.rf_write, bus.rf_write_address, prev_addr); end
            end
            prev_addr = exp_alu ? 5'd9 : 5'd10;
            step();
        end
        idle_inputs();
    endtask

    task automatic test_underflow();
        do_reset();
        bus.mem_valid = 1'b1; bus.mem_address = 5'd3; bus.mem_data = 32'h0000_0033;
        #1;
        tests++; if (bus.mem_ready !== 1'b1) begin fails++; $display("FAIL uf_grant got %b want 1", bus.mem_ready); end
        step();
        bus.mem_valid = 1'b0;
        #1;
        tests++; if (bus.sb_error !== 1'b1) begin fails++; $display("FAIL uf_err got %b want 1", bus.sb_error); end
        tests++; if (bus.rf_write !== 1'b1 || bus.rf_write_address !== 5'd3 || bus.rf_write_data !== 32'h33) begin
            fails++; $display("FAIL uf_write got %b/%0d/%h want 1/3/33", bus.rf_write, bus.rf_write_address, bus.rf_write_data); end
        bus.read_address2 = 5'd3;
        #1;
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL uf_cnt_zero stall got %b want 0", bus.stall); end
        step(); step();
        tests++; if (bus.sb_error !== 1'b1) begin fails++; $display("FAIL uf_sticky got %b want 1", bus.sb_error); end
        do_reset();
        #1;
        tests++; if (bus.sb_error !== 1'b0) begin fails++; $display("FAIL uf_cleared got %b want 0", bus.sb_error); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.issue_valid = 1'b1; bus.issue_address = 5'd1;
        step();
        bus.issue_address = 5'd2;
        step();
        bus.issue_valid = 1'b0;
        bus.read_address0 = 5'd1; bus.read_address1 = 5'd2;
        #1;
        tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL mid_pending got %b want 1", bus.stall); end
        bus.alu_valid = 1'b1; bus.alu_address = 5'd1; bus.alu_data = 32'h0101_0101;
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.alu_valid = 1'b0;
        #1;
        tests++; if (bus.rf_write !== 1'b0) begin fails++; $display("FAIL mid_rf_write got %b want 0", bus.rf_write); end
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL mid_stall got %b want 0", bus.stall); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_hazard();
        test_saturation();
        test_issue_commit_same();
        test_priority();
        test_underflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
